// File: rtl/press_run_counter.sv
// press_run_counter
//   Push-button run/stop counter. The raw button is synchronised and
//   debounced. Each accepted press toggles run/stop. Holding the button
//   long enough clears the count and stops the counter. While running,
//   the count steps up or down once per PRESCALE cycles, and either wraps
//   or saturates at 0 / MAX_COUNT.
// Ports
//   clk, rst     clock, synchronous active-high reset
//   press        raw asynchronous button, active-high
//   dir          0 = up, 1 = down, sampled on each tick
//   count        current count (0..MAX_COUNT)
//   running      counting enabled
//   press_event  1-cycle pulse per accepted press
//   long_press   1-cycle pulse when a long hold is detected
//   tc           1-cycle pulse on wrap or saturate hit
module press_run_counter #(
  parameter int WIDTH             = 4,
  parameter int MAX_COUNT         = 2**WIDTH-1,
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 16,
  parameter int PRESCALE          = 1,
  parameter int SATURATE          = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             press,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             press_event,
  output logic             long_press,
  output logic             tc
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 2);
  localparam int PW = $clog2(PRESCALE + 1);
  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_COUNT);
  localparam logic [DW-1:0]    DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]    HLONG = HW'(LONG_PRESS_CYCLES);
  // Hold counter parks one past the long threshold so the pulse never repeats.
  localparam logic [HW-1:0]    HSAT  = HW'(LONG_PRESS_CYCLES + 1);
  localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic             ps1_q, ps1_d, ps2_q, ps2_d;
  logic             db_q, db_d, db_dly_q, db_dly_d;
  logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             press_event_q, press_event_d;
  logic             long_press_q, long_press_d;
  logic             tc_q, tc_d;

  logic run_int, rise, long_evt, tick, at_limit, sat_hit;

  assign rise     = db_q & ~db_dly_q;
  assign long_evt = db_q && (hold_q == HLONG);
  assign tick     = run_int && (pre_q == PLAST);
  assign at_limit = dir ? (count_q == '0) : (count_q == MAXV);
  // A saturate stop only counts when no clear or toggle wins the cycle.
  assign sat_hit  = tick && at_limit && (SATURATE != 0) && !rise && !long_evt;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_STOP;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: if (rise && !long_evt) state_d = ST_RUN;
      ST_RUN:  if (long_evt || rise || sat_hit) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run_int = (state_q == ST_RUN);
  end

  // Datapath next state
  always_comb begin
    ps1_d     = press;
    ps2_d     = ps1_q;
    db_d      = db_q;
    deb_cnt_d = '0;
    if (ps2_q != db_q) begin
      if (deb_cnt_q == DLAST) db_d = ps2_q;
      else                    deb_cnt_d = deb_cnt_q + 1'b1;
    end
    db_dly_d = db_q;

    hold_d = '0;
    if (db_q) hold_d = (hold_q == HSAT) ? hold_q : hold_q + 1'b1;

    press_event_d = rise;
    long_press_d  = long_evt;
    tc_d          = 1'b0;
    count_d       = count_q;

    if (!run_int || tick) pre_d = '0;
    else                  pre_d = pre_q + 1'b1;

    if (long_evt) begin
      count_d = '0;
      pre_d   = '0;
    end else if (rise) begin
      // Toggle owns the cycle: no step, no tc.
      pre_d = '0;
    end else if (tick) begin
      if (!at_limit) begin
        count_d = dir ? count_q - 1'b1 : count_q + 1'b1;
      end else begin
        tc_d = 1'b1;
        if (SATURATE == 0) count_d = dir ? MAXV : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps1_q         <= 1'b0;
      ps2_q         <= 1'b0;
      db_q          <= 1'b0;
      db_dly_q      <= 1'b0;
      deb_cnt_q     <= '0;
      hold_q        <= '0;
      pre_q         <= '0;
      count_q       <= '0;
      press_event_q <= 1'b0;
      long_press_q  <= 1'b0;
      tc_q          <= 1'b0;
    end else begin
      ps1_q         <= ps1_d;
      ps2_q         <= ps2_d;
      db_q          <= db_d;
      db_dly_q      <= db_dly_d;
      deb_cnt_q     <= deb_cnt_d;
      hold_q        <= hold_d;
      pre_q         <= pre_d;
      count_q       <= count_d;
      press_event_q <= press_event_d;
      long_press_q  <= long_press_d;
      tc_q          <= tc_d;
    end
  end

  assign count       = count_q;
  assign running     = run_int;
  assign press_event = press_event_q;
  assign long_press  = long_press_q;
  assign tc          = tc_q;

endmodule

// File: tb/tb_press_run_counter.sv
// Bench for press_run_counter. Three instances share stimulus:
//   cfg0: PRESCALE=1 wrap, cfg1: PRESCALE=3 wrap, cfg2: PRESCALE=1 saturate.
// All use WIDTH=4, MAX_COUNT=9, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16.
module tb_press_run_counter;
  localparam int MAXC = 9;
  localparam int DB   = 4;
  localparam int LP   = 16;

  logic clk = 1'b0;
  logic rst, press, dir;
  logic [3:0] cnt_o [3];
  logic       run_o [3];
  logic       pe_o  [3];
  logic       lp_o  [3];
  logic       tc_o  [3];

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  press_run_counter #(.WIDTH(4), .MAX_COUNT(9), .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(16), .PRESCALE(1), .SATURATE(0)) u_cfg0 (
    .clk(clk), .rst(rst), .press(press), .dir(dir), .count(cnt_o[0]),
    .running(run_o[0]), .press_event(pe_o[0]), .long_press(lp_o[0]), .tc(tc_o[0]));

  press_run_counter #(.WIDTH(4), .MAX_COUNT(9), .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(16), .PRESCALE(3), .SATURATE(0)) u_cfg1 (
    .clk(clk), .rst(rst), .press(press), .dir(dir), .count(cnt_o[1]),
    .running(run_o[1]), .press_event(pe_o[1]), .long_press(lp_o[1]), .tc(tc_o[1]));

  press_run_counter #(.WIDTH(4), .MAX_COUNT(9), .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(16), .PRESCALE(1), .SATURATE(1)) u_cfg2 (
    .clk(clk), .rst(rst), .press(press), .dir(dir), .count(cnt_o[2]),
    .running(run_o[2]), .press_event(pe_o[2]), .long_press(lp_o[2]), .tc(tc_o[2]));

  // Reference model. Front end: two-sample delay, then a level is accepted
  // once the last DB samples all disagree with it. Back end per config.
  bit m_ps1, m_ps2, m_db, m_dbd;
  int m_high;          // cycles the debounced level has been high (capped)
  bit hist[$];         // recent synchronised samples
  int m_cnt [3];
  int m_pre [3];
  bit m_run [3];
  bit m_pe  [3];
  bit m_lp  [3];
  bit m_tc  [3];

  task automatic model_step();
    if (rst) begin
      m_ps1 = 0; m_ps2 = 0; m_db = 0; m_dbd = 0; m_high = 0;
      hist.delete();
      for (int c = 0; c < 3; c++) begin
        m_cnt[c] = 0; m_pre[c] = 0; m_run[c] = 0;
        m_pe[c] = 0; m_lp[c] = 0; m_tc[c] = 0;
      end
    end else begin
      bit rise, lng, acc;
      hist.push_back(m_ps2);
      if (hist.size() > DB) void'(hist.pop_front());
      acc = (hist.size() == DB);
      foreach (hist[i]) if (hist[i] == m_db) acc = 0;
      rise = m_db && !m_dbd;
      lng  = m_db && (m_high == LP);
      m_high = m_db ? ((m_high > LP) ? m_high : m_high + 1) : 0;
      m_dbd = m_db;
      if (acc) begin m_db = !m_db; hist.delete(); end
      m_ps2 = m_ps1;
      m_ps1 = press;
      for (int c = 0; c < 3; c++) begin
        int p;
        bit sat, tk;
        p   = (c == 1) ? 3 : 1;
        sat = (c == 2);
        tk  = m_run[c] && (m_pre[c] == p - 1);
        m_pe[c] = rise;
        m_lp[c] = lng;
        m_tc[c] = 0;
        if (lng) begin
          m_cnt[c] = 0; m_run[c] = 0; m_pre[c] = 0;
        end else if (rise) begin
          m_run[c] = !m_run[c]; m_pre[c] = 0;
        end else if (tk) begin
          m_pre[c] = 0;
          if (!dir && m_cnt[c] < MAXC)      m_cnt[c] = m_cnt[c] + 1;
          else if (dir && m_cnt[c] > 0)     m_cnt[c] = m_cnt[c] - 1;
          else begin
            m_tc[c] = 1;
            if (sat) m_run[c] = 0;
            else     m_cnt[c] = dir ? 0 + MAXC : 0;
          end
        end else begin
          m_pre[c] = m_run[c] ? m_pre[c] + 1 : 0;
        end
      end
    end
  endtask

  task automatic check(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // One clock: model advances with the DUT edge, outputs compared mid-cycle.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (chk_en)
      for (int c = 0; c < 3; c++)
        check($sformatf("model_cfg%0d{cnt,run,pe,lp,tc}", c),
              {cnt_o[c], run_o[c], pe_o[c], lp_o[c], tc_o[c]},
              {4'(m_cnt[c]), m_run[c], m_pe[c], m_lp[c], m_tc[c]});
  endtask

  task automatic do_reset(int n);
    rst = 1;
    repeat (n) cyc();
    rst = 0;
  endtask

  task automatic pulse(int hi, int lo);
    press = 1;
    repeat (hi) cyc();
    press = 0;
    repeat (lo) cyc();
  endtask

  // Waits for a press_event on cfg0; an expired bound is a failed check.
  task automatic wait_pe(string nm);
    int n = 0;
    while (!pe_o[0] && n < 20) begin cyc(); n++; end
    check({nm, "_pe_seen"}, pe_o[0], 1);
  endtask

  typedef struct {
    int len;
    int exp_pe;
    int exp_lp;
    int exp_run;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n, m, npe, nlp, c0, v;
    tbl[0] = '{1,  0, 0, 0};
    tbl[1] = '{3,  0, 0, 0};
    tbl[2] = '{4,  1, 0, 1};
    tbl[3] = '{8,  1, 0, 1};
    tbl[4] = '{16, 1, 0, 1};
    tbl[5] = '{17, 1, 1, 0};
    tbl[6] = '{40, 1, 1, 0};

    rst = 1; press = 0; dir = 0;
    cyc(); cyc();
    chk_en = 1;
    check("reset_cnt", cnt_o[0], 0);
    check("reset_run", run_o[0], 0);

    // Pulse-length table: events, long presses and final run state.
    foreach (tbl[i]) begin
      do_reset(2);
      dir = 0; npe = 0; nlp = 0;
      press = 1;
      repeat (tbl[i].len) begin cyc(); npe += pe_o[0]; nlp += lp_o[0]; end
      press = 0;
      repeat (40) begin cyc(); npe += pe_o[0]; nlp += lp_o[0]; end
      check($sformatf("tbl%0d_events", i), npe, tbl[i].exp_pe);
      check($sformatf("tbl%0d_long", i), nlp, tbl[i].exp_lp);
      check($sformatf("tbl%0d_run", i), run_o[0], tbl[i].exp_run);
    end

    // Reset held with press high, then normal acceptance and latency.
    rst = 1; press = 1; dir = 0;
    repeat (2) begin
      cyc();
      check("rst_press_cnt", cnt_o[0], 0);
      check("rst_press_run", run_o[0], 0);
      check("rst_press_pe", pe_o[0], 0);
    end
    rst = 0;
    n = 0;
    while (!pe_o[0] && n < 20) begin cyc(); n++; end
    check("press_latency", n, 7);
    check("run_after_press", run_o[0], 1);
    press = 0;
    n = 0;
    while (!tc_o[0] && n < 30) begin cyc(); n++; end
    check("up_wrap_tc", tc_o[0], 1);
    check("up_wrap_cnt", cnt_o[0], 0);
    check("sat_hit_tc", tc_o[2], 1);
    check("sat_hit_cnt", cnt_o[2], 9);
    check("sat_hit_run", run_o[2], 0);
    cyc();
    check("tc_one_cycle", tc_o[0], 0);
    check("after_wrap_cnt", cnt_o[0], 1);
    check("sat_hold_cnt", cnt_o[2], 9);

    // Second press: cfg0 stops and freezes, cfg2 restarts at its limit.
    repeat (10) cyc();
    press = 1;
    wait_pe("second");
    press = 0;
    check("second_press_stop", run_o[0], 0);
    check("sat_restart_run", run_o[2], 1);
    c0 = cnt_o[0];
    cyc();
    check("frozen_cnt", cnt_o[0], c0);
    check("sat_restart_tc", tc_o[2], 1);
    check("sat_restart_stop", run_o[2], 0);
    check("sat_restart_cnt", cnt_o[2], 9);
    repeat (30) cyc();

    // Down wrap from 0 and the PRESCALE=3 step spacing.
    do_reset(2);
    dir = 1;
    press = 1;
    wait_pe("down");
    press = 0;
    cyc();
    check("down_wrap_cnt", cnt_o[0], 9);
    check("down_wrap_tc", tc_o[0], 1);
    check("sat_down_stop", run_o[2], 0);
    check("sat_down_cnt", cnt_o[2], 0);
    n = 1;
    while (cnt_o[1] == 0 && n < 10) begin cyc(); n++; end
    check("p3_first_step", n, 3);
    check("p3_first_cnt", cnt_o[1], 9);
    m = 0; v = cnt_o[1];
    while (cnt_o[1] == v && m < 10) begin cyc(); m++; end
    check("p3_interval", m, 3);
    check("p3_second_cnt", cnt_o[1], 8);

    // Long press while running: toggle to stop, then clear 16 cycles later.
    do_reset(2);
    dir = 0;
    pulse(8, 10);
    check("long_pre_run", run_o[0], 1);
    press = 1;
    wait_pe("long");
    check("long_toggle_stop", run_o[0], 0);
    n = 0;
    while (!lp_o[0] && n < 40) begin cyc(); n++; end
    check("long_gap", n, 16);
    check("long_cnt", cnt_o[0], 0);
    check("long_run", run_o[0], 0);
    repeat (10) cyc();
    press = 0;
    npe = 0;
    repeat (30) begin cyc(); npe += pe_o[0] + lp_o[0]; end
    check("release_no_event", npe, 0);

    // Reset landing mid-debounce discards the press.
    press = 1;
    repeat (3) cyc();
    rst = 1; cyc(); rst = 0;
    repeat (2) cyc();
    press = 0;
    npe = 0;
    repeat (20) begin cyc(); npe += pe_o[0]; end
    check("rst_mid_debounce", npe, 0);
    check("rst_mid_run", run_o[0], 0);

    // Random pulses, direction changes and occasional resets.
    repeat (500) begin
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 2));
      dir = 1'($urandom_range(0, 1));
      pulse($urandom_range(1, 30), $urandom_range(1, 30));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
